// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry add/subtract.
// The DATA_WIDTH-bit operation is split into STAGES chunks of CW bits. Each
// stage adds one chunk and registers the partial result, and the carry passes
// to the next stage through a register.
// Operand chunks that have not been added yet travel forward alongside the
// partial result (skew). Finished sum chunks also travel forward (deskew), so
// s is fully aligned once it leaves the last stage.
// Valid/ready handshake with full backpressure; in_rd is combinational from
// out_rd through the per-stage ready chain.
// Legal parameters: 1 <= STAGES <= DATA_WIDTH, DATA_WIDTH % STAGES == 0.
module pipelined_ripple_adder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  ci,
  input  logic                  sub,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] s,
  output logic                  co,
  output logic                  out_vld,
  input  logic                  out_rd
);

  localparam int unsigned CW = DATA_WIDTH / STAGES;

  // Per-stage inputs: element k is what stage k consumes (element 0 comes from the ports).
  logic [DATA_WIDTH-1:0] w_a_in [STAGES];  // partial sum below chunk k, operand A from chunk k up
  logic [DATA_WIDTH-1:0] w_b_in [STAGES];  // effective operand B (already inverted for subtract)
  logic [STAGES-1:0]     w_c_in;           // carry into chunk k
  logic [STAGES-1:0]     w_vld_in;         // upstream valid seen by stage k
  logic [STAGES:0]       w_rd;             // ready into stage k; w_rd[STAGES] is the consumer

  // Operand conditioning: subtract is a + ~b + 1, and ci inverts into a borrow.
  assign w_a_in[0]    = a;
  assign w_b_in[0]    = b ^ {DATA_WIDTH{sub}};
  assign w_c_in[0]    = ci ^ sub;
  assign w_vld_in[0]  = in_vld;
  assign w_rd[STAGES] = out_rd;
  assign in_rd        = w_rd[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                  r_vld;
    logic                  r_c;
    logic [DATA_WIDTH-1:0] r_d;
    logic [CW-1:0]         w_sum;
    logic                  w_co;
    logic                  w_ld;
    logic [DATA_WIDTH-1:0] w_d_nxt;

    // Stage k can take a beat when it is empty or its own beat moves on this cycle.
    assign w_rd[k] = !r_vld || w_rd[k+1];
    assign w_ld    = w_rd[k] && w_vld_in[k];

    // Ripple adder for chunk k.
    assign {w_co, w_sum} = (CW+1)'(w_a_in[k][k*CW +: CW])
                         + (CW+1)'(w_b_in[k][k*CW +: CW])
                         + (CW+1)'(w_c_in[k]);

    // Replace chunk k of the travelling word with its sum; other bits pass through.
    always_comb begin
      w_d_nxt               = w_a_in[k];
      w_d_nxt[k*CW +: CW]   = w_sum;
    end

    // Stage valid follows upstream whenever the stage is allowed to advance.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
      end else if (w_rd[k]) begin
        r_vld <= w_vld_in[k];
      end
    end

    // Data and carry registers only update on a real beat, so held results stay put.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_d <= '0;
        r_c <= 1'b0;
      end else if (w_ld) begin
        r_d <= w_d_nxt;
        r_c <= w_co;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [DATA_WIDTH-1:0] r_b;

      // Operand B skew register feeding the next chunk.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_b <= '0;
        end else if (w_ld) begin
          r_b <= w_b_in[k];
        end
      end

      assign w_a_in[k+1]   = r_d;
      assign w_b_in[k+1]   = r_b;
      assign w_c_in[k+1]   = r_c;
      assign w_vld_in[k+1] = r_vld;
    end else begin : g_out
      assign s       = r_d;
      assign co      = r_c;
      assign out_vld = r_vld;
    end
  end

endmodule
